mem_decoder: RTL and testbench

MEM_DECODER -- requirements
Module: mem_decoder

---
 rtl/mem_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_decoder.sv
// mem_decoder
// Address decoder / bridge between a single memory master and N_SLV slave
// regions. A request is accepted while idle, checked for decode and alignment
// errors, forwarded to the one slave whose region contains it as a
// single-cycle strobe, and completed with a one-cycle mem_valid pulse. That
// pulse carries the slave's read data, or an error if the slave stays silent
// for TIMEOUT cycles.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   mem_addr                 byte address from master
//   mem_read_valid           master read request
//   mem_write_valid          master write request
//   mem_write_data           store data
//   mem_width                0=byte, 1=half, 2=word (3 is illegal)
//   mem_ready                high only while idle and able to accept
//   mem_read_data            captured read data, 0 after a write or an error
//   mem_valid, mem_err       one-cycle completion pulse and its error flag
//   slv_addr                 offset into the selected region
//   slv_write_data           latched store data
//   slv_width                latched access width
//   slv_read_valid           one-hot read strobe, high for the first busy cycle only
//   slv_write_valid          one-hot write strobe, high for the first busy cycle only
//   slv_read_data, slv_valid per-slave response buses
module mem_decoder #(
    parameter int                   N_SLV   = 2,
    parameter logic [N_SLV*32-1:0]  BASES   = {32'h1000, 32'h0},
    parameter logic [N_SLV*32-1:0]  SIZES   = {32'h1000, 32'h1000},
    parameter int                   TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr,
    input  logic                  mem_read_valid,
    input  logic                  mem_write_valid,
    input  logic [31:0]           mem_write_data,
    input  logic [1:0]            mem_width,
    output logic                  mem_ready,
    output logic [31:0]           mem_read_data,
    output logic                  mem_valid,
    output logic                  mem_err,
    output logic [31:0]           slv_addr,
    output logic [31:0]           slv_write_data,
    output logic [1:0]            slv_width,
    output logic [N_SLV-1:0]      slv_read_valid,
    output logic [N_SLV-1:0]      slv_write_valid,
    input  logic [N_SLV*32-1:0]   slv_read_data,
    input  logic [N_SLV-1:0]      slv_valid
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      width_q, width_d;
    logic            isWrite_q, isWrite_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            hitFound;
    logic [IW-1:0]   hitIdx;
    logic [32:0]     hitBase;
    logic [32:0]     hitEnd;
    logic [2:0]      accessBytes;
    logic            reqErr;
    logic            selValid;
    logic [31:0]     selData;

    // Region decode. Bounds are compared at 33 bits so a region ending at
    // 4 GiB cannot wrap. Scanning from the top index downward lets the lowest
    // matching index overwrite any higher one, so the lowest index wins on overlap.
    always_comb begin
        logic [32:0] b;
        logic [32:0] e;
        hitFound = 1'b0;
        hitIdx   = '0;
        hitBase  = '0;
        hitEnd   = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            b = {1'b0, BASES[32*i +: 32]};
            e = b + {1'b0, SIZES[32*i +: 32]};
            if (({1'b0, mem_addr} >= b) && ({1'b0, mem_addr} < e)) begin
                hitFound = 1'b1;
                hitIdx   = IW'(i);
                hitBase  = b;
                hitEnd   = e;
            end
        end
    end

    // Request legality. The whole access, not only its first byte, has to
    // fit inside the selected region.
    always_comb begin
        accessBytes = 3'd1;
        case (mem_width)
            2'd1:    accessBytes = 3'd2;
            2'd2:    accessBytes = 3'd4;
            default: accessBytes = 3'd1;
        endcase
        reqErr = !hitFound
              || (mem_read_valid && mem_write_valid)
              || (mem_width == 2'd3)
              || ((mem_width == 2'd1) && mem_addr[0])
              || ((mem_width == 2'd2) && (mem_addr[1:0] != 2'b00))
              || (({1'b0, mem_addr} + {30'd0, accessBytes}) > hitEnd);
    end

    // Only the selected slave's response is observed.
    always_comb begin
        selValid = 1'b0;
        selData  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q == IW'(i)) begin
                selValid = slv_valid[i];
                selData  = slv_read_data[32*i +: 32];
            end
        end
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            width_q   <= '0;
            isWrite_q <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            width_q   <= width_d;
            isWrite_q <= isWrite_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic. An erroneous request skips BUSY entirely. The slave
    // fields are latched only for legal requests so the slave bus never shows
    // a bad address. cnt_q counts completed silent BUSY cycles, so the last
    // permitted cycle is the one where it reads TIMEOUT-1.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        width_d   = width_q;
        isWrite_d = isWrite_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (mem_read_valid || mem_write_valid) begin
                    if (reqErr) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d   = BUSY;
                        addr_d    = mem_addr - hitBase[31:0];
                        wdata_d   = mem_write_data;
                        width_d   = mem_width;
                        isWrite_d = mem_write_valid;
                        sel_d     = hitIdx;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (selValid) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = isWrite_q ? 32'd0 : selData;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. The strobe lives only in the first BUSY cycle, which is
    // exactly when the timeout counter is still zero.
    always_comb begin
        logic strobe;
        strobe          = (state_q == BUSY) && (cnt_q == '0);
        mem_ready       = (state_q == IDLE);
        mem_valid       = (state_q == RESP);
        mem_err         = (state_q == RESP) && err_q;
        mem_read_data   = rdata_q;
        slv_addr        = addr_q;
        slv_write_data  = wdata_q;
        slv_width       = width_q;
        slv_read_valid  = '0;
        slv_write_valid = '0;
        for (int i = 0; i < N_SLV; i++) begin
            slv_read_valid[i]  = strobe && !isWrite_q && (sel_q == IW'(i));
            slv_write_valid[i] = strobe &&  isWrite_q && (sel_q == IW'(i));
        end
    end

endmodule

// File: tb/tb_mem_decoder.sv
// tb_mem_decoder
// Directed and randomized transactions against mem_decoder with its default
// two-region map. The expected decode, offset, error and read data come from
// a region-table model working on plain integer address arithmetic.
module tb_mem_decoder;

    localparam int N_SLV   = 2;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        mem_addr;
    logic               mem_read_valid;
    logic               mem_write_valid;
    logic [31:0]        mem_write_data;
    logic [1:0]         mem_width;
    logic               mem_ready;
    logic [31:0]        mem_read_data;
    logic               mem_valid;
    logic               mem_err;
    logic [31:0]        slv_addr;
    logic [31:0]        slv_write_data;
    logic [1:0]         slv_width;
    logic [N_SLV-1:0]   slv_read_valid;
    logic [N_SLV-1:0]   slv_write_valid;
    logic [N_SLV*32-1:0] slv_read_data;
    logic [N_SLV-1:0]   slv_valid;

    int checks = 0;
    int errors = 0;

    // Region table: slave 0 at 0x0000, slave 1 at 0x1000, 4 KiB each.
    longint regionBase [N_SLV] = '{64'h0, 64'h1000};
    longint regionSize [N_SLV] = '{64'h1000, 64'h1000};

    mem_decoder #(
        .N_SLV   (N_SLV),
        .BASES   ({32'h1000, 32'h0}),
        .SIZES   ({32'h1000, 32'h1000}),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_addr        (mem_addr),
        .mem_read_valid  (mem_read_valid),
        .mem_write_valid (mem_write_valid),
        .mem_write_data  (mem_write_data),
        .mem_width       (mem_width),
        .mem_ready       (mem_ready),
        .mem_read_data   (mem_read_data),
        .mem_valid       (mem_valid),
        .mem_err         (mem_err),
        .slv_addr        (slv_addr),
        .slv_write_data  (slv_write_data),
        .slv_width       (slv_width),
        .slv_read_valid  (slv_read_valid),
        .slv_write_valid (slv_write_valid),
        .slv_read_data   (slv_read_data),
        .slv_valid       (slv_valid)
    );

    always #5 clk = ~clk;

    // Safety net against a DUT that never returns to idle.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: which region holds the address, the offset within
    // it, and whether the request is illegal.
    task automatic modelDecode(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [1:0] width, output bit err, output int sel,
                               output logic [31:0] off);
        longint a;
        longint nBytes;
        a      = longint'(addr);
        nBytes = (width == 2'd2) ? 4 : (width == 2'd1) ? 2 : 1;
        sel    = -1;
        off    = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel < 0 && a >= regionBase[i] && a < regionBase[i] + regionSize[i])
                sel = i;
        end
        err = (rd && wr) || (width == 2'd3)
           || (width == 2'd1 && (a % 2) != 0)
           || (width == 2'd2 && (a % 4) != 0)
           || (sel < 0);
        if (sel >= 0) begin
            if (a + nBytes > regionBase[sel] + regionSize[sel]) err = 1'b1;
            off = 32'(a - regionBase[sel]);
        end
    endtask

    // One full transaction. respDelay is the busy cycle (0 = first) in which
    // the selected slave answers; a negative value means it never answers.
    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [31:0] wdata, input logic [1:0] width,
                                 input int respDelay, input logic [31:0] rdata,
                                 input bit otherPulse, input bit presentInResp);
        bit          expErr;
        bit          responded;
        int          sel;
        logic [31:0] off;
        logic [31:0] expData;
        logic [N_SLV-1:0] oneHot;

        modelDecode(addr, rd, wr, width, expErr, sel, off);
        checkOutput("ready_idle", 32'(mem_ready), 32'd1);
        mem_addr        = addr;
        mem_read_valid  = rd;
        mem_write_valid = wr;
        mem_write_data  = wdata;
        mem_width       = width;
        step();
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
        mem_addr        = $urandom;
        mem_write_data  = $urandom;
        mem_width       = 2'($urandom_range(0, 3));

        responded = 1'b0;
        if (expErr) begin
            checkOutput("err_valid", 32'(mem_valid), 32'd1);
            checkOutput("err_flag", 32'(mem_err), 32'd1);
            checkOutput("err_rdata", mem_read_data, 32'd0);
            checkOutput("err_nostrobe", 32'({slv_read_valid, slv_write_valid}), 32'd0);
            checkOutput("err_notready", 32'(mem_ready), 32'd0);
            expData = 32'd0;
        end else begin
            oneHot = '0;
            oneHot[sel] = 1'b1;
            checkOutput("busy_novalid", 32'(mem_valid), 32'd0);
            checkOutput("busy_notready", 32'(mem_ready), 32'd0);
            checkOutput("rd_strobe", 32'(slv_read_valid), rd ? 32'(oneHot) : 32'd0);
            checkOutput("wr_strobe", 32'(slv_write_valid), wr ? 32'(oneHot) : 32'd0);
            checkOutput("slv_addr", slv_addr, off);
            checkOutput("slv_width", 32'(slv_width), 32'(width));
            checkOutput("slv_wdata", slv_write_data, wdata);
            for (int k = 0; k < TIMEOUT; k++) begin
                if (k > 0) begin
                    checkOutput("strobe_once", 32'({slv_read_valid, slv_write_valid}), 32'd0);
                    checkOutput("addr_stable", slv_addr, off);
                    checkOutput("busy_hold", 32'(mem_valid), 32'd0);
                end
                slv_valid     = '0;
                slv_read_data = {$urandom, $urandom};
                if (otherPulse && k == 0) slv_valid[1 - sel] = 1'b1;
                if (k == respDelay) begin
                    slv_valid[sel] = 1'b1;
                    slv_read_data[32*sel +: 32] = rdata;
                end
                step();
                slv_valid = '0;
                if (k == respDelay) begin
                    responded = 1'b1;
                    break;
                end
            end
            expData = (rd && responded) ? rdata : 32'd0;
            checkOutput("resp_valid", 32'(mem_valid), 32'd1);
            checkOutput("resp_err", 32'(mem_err), responded ? 32'd0 : 32'd1);
            checkOutput("resp_rdata", mem_read_data, expData);
        end

        if (presentInResp) begin
            mem_addr        = 32'h1000;
            mem_width       = 2'd0;
            mem_read_valid  = 1'b1;
        end
        step();
        mem_read_valid = 1'b0;
        checkOutput("pulse_once", 32'(mem_valid), 32'd0);
        checkOutput("back_idle", 32'(mem_ready), 32'd1);
        checkOutput("idle_nostrobe", 32'({slv_read_valid, slv_write_valid}), 32'd0);
        checkOutput("rdata_held", mem_read_data, expData);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(mem_ready), 32'd1);
        checkOutput({tag, "_valid"}, 32'(mem_valid), 32'd0);
        checkOutput({tag, "_err"}, 32'(mem_err), 32'd0);
        checkOutput({tag, "_rdata"}, mem_read_data, 32'd0);
        checkOutput({tag, "_strobes"}, 32'({slv_read_valid, slv_write_valid}), 32'd0);
        checkOutput({tag, "_saddr"}, slv_addr, 32'd0);
        checkOutput({tag, "_swdata"}, slv_write_data, 32'd0);
        checkOutput({tag, "_swidth"}, 32'(slv_width), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        rd;
        logic        wr;
        int          r;
        int          dly;

        rst             = 1'b0;
        mem_addr        = '0;
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
        mem_write_data  = '0;
        mem_width       = '0;
        slv_read_data   = '0;
        slv_valid       = '0;
        #12;
        checkResetOutputs("reset");
        step();
        rst = 1'b1;
        step();

        // Word read from slave 1 answered in the first busy cycle.
        applyStimulus(32'h1004, 1, 0, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0, 0);
        // Last byte of slave 0 and first byte of slave 1.
        applyStimulus(32'h0FFF, 1, 0, 32'h0, 2'd0, 1, 32'h000000A5, 0, 0);
        applyStimulus(32'h1000, 0, 1, 32'h5A, 2'd0, 2, 32'h12345678, 0, 0);
        // Unmapped, misaligned, illegal width, read and write together.
        applyStimulus(32'h2000, 1, 0, 32'h0, 2'd0, 0, 32'h0, 0, 0);
        applyStimulus(32'h1002, 1, 0, 32'h0, 2'd2, 0, 32'h0, 0, 0);
        applyStimulus(32'h0001, 1, 0, 32'h0, 2'd1, 0, 32'h0, 0, 0);
        applyStimulus(32'h0000, 1, 0, 32'h0, 2'd3, 0, 32'h0, 0, 0);
        applyStimulus(32'h0000, 1, 1, 32'h0, 2'd0, 0, 32'h0, 0, 0);
        // Slave 0 never answers a write.
        applyStimulus(32'h0010, 0, 1, 32'hCAFEF00D, 2'd2, -1, 32'h0, 0, 0);
        // Slave 1 pulses while slave 0 is being served.
        applyStimulus(32'h0020, 1, 0, 32'h0, 2'd2, 3, 32'h0BADF00D, 1, 0);
        // A request presented during the response cycle must wait for idle.
        applyStimulus(32'h1FFC, 1, 0, 32'h0, 2'd2, 0, 32'h13579BDF, 0, 1);
        applyStimulus(32'h1FFE, 0, 1, 32'hBEEF, 2'd1, 4, 32'h0, 0, 0);

        // Reset in the middle of a busy transaction.
        mem_addr       = 32'h1010;
        mem_width      = 2'd2;
        mem_write_data = 32'h77;
        mem_read_valid = 1'b1;
        step();
        mem_read_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checkResetOutputs("midreset");
        step();
        rst = 1'b1;
        slv_valid = 2'b11;
        step();
        slv_valid = '0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("no_pulse_after_reset", 32'(mem_valid), 32'd0);
            step();
        end
        applyStimulus(32'h1010, 1, 0, 32'h0, 2'd2, 1, 32'h2468ACE0, 0, 0);

        // Randomized traffic around region boundaries and elsewhere.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h0FFC + 32'($urandom_range(0, 7));
                1:       a = 32'h1FFC + 32'($urandom_range(0, 7));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 32'h2100));
            endcase
            r   = int'($urandom_range(0, 9));
            rd  = (r == 0) || (r < 5);
            wr  = (r == 0) || (r >= 5);
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            applyStimulus(a, rd, wr, $urandom, 2'($urandom_range(0, 3)), dly, $urandom,
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
